// File: rtl/h14tx_pkg.sv
`default_nettype none
// ============================================================================
// h14tx_pkg : shared HDMI 1.4 TX types, period encodings and timing lengths
// Rev 1.1 : data-island scheduling constants added
// ============================================================================
package h14tx_pkg;

    localparam int IslandPreambleLen   = 8;
    localparam int GuardLen            = 2;
    localparam int PacketCycles        = 32;
    localparam int MinControlLen       = 12;
    localparam int VideoLeadLen        = 10;
    localparam int MaxPacketsPerIsland = 18;

    typedef enum logic [2:0] {
        Control            = 3'd0,
        VideoPreamble      = 3'd1,
        VideoGuard         = 3'd2,
        VideoActive        = 3'd3,
        DataIslandPreamble = 3'd4,
        DataIslandGuard    = 3'd5,
        DataIslandActive   = 3'd6
    } period_t;

    typedef struct packed {
        logic [23:0]      header;
        logic [3:0][55:0] sub;
    } packet_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRE    = 3'd1,
        S_LGUARD = 3'd2,
        S_ACTIVE = 3'd3,
        S_TGUARD = 3'd4
    } island_state_t;

endpackage
`default_nettype wire

// File: rtl/h14tx_island_scheduler_if.sv
`default_nettype none
// ============================================================================
// h14tx_island_scheduler_if : packet source handshake and island output bus
// Rev 1.0
// ============================================================================
interface h14tx_island_scheduler_if import h14tx_pkg::*; #(
    parameter int NumSources = 3,
    parameter int FifoDepth  = 4
);
    logic [NumSources-1:0]          src_valid;
    packet_t [NumSources-1:0]       src_packet;
    logic [NumSources-1:0]          src_ready;
    period_t                        period;
    packet_t                        packet;
    logic                           pkt_start;
    logic [$clog2(FifoDepth):0]     fifo_level;

    modport master (
        output src_valid, src_packet,
        input  src_ready, period, packet, pkt_start, fifo_level
    );

    modport slave (
        input  src_valid, src_packet,
        output src_ready, period, packet, pkt_start, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/h14tx_packet_fifo.sv
`default_nettype none
// ============================================================================
// h14tx_packet_fifo : synchronous packet FIFO, power-of-two depth
// Rev 1.0
// ============================================================================
module h14tx_packet_fifo import h14tx_pkg::*; #(
    parameter int Depth = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   push,
    input  wire packet_t                push_data,
    input  wire logic                   pop,
    output packet_t                     head,
    output logic [$clog2(Depth):0]      level,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(Depth);

    packet_t        r_mem [Depth];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_level;
    logic           w_do_push;
    logic           w_do_pop;

    assign full      = (r_level == (AW+1)'(Depth));
    assign empty     = (r_level == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd];
    assign level     = r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= push_data;
    end
endmodule
`default_nettype wire

// File: rtl/h14tx_island_scheduler.sv
`default_nettype none
// ============================================================================
// h14tx_island_scheduler : period generator with round-robin packet ingress
// and per-line data-island scheduling.  Rev 1.0
// ============================================================================
module h14tx_island_scheduler import h14tx_pkg::*; #(
    parameter int BitWidth     = 12,
    parameter int BitHeight    = 11,
    parameter int FrameWidth   = 1650,
    parameter int FrameHeight  = 750,
    parameter int ActiveWidth  = 1280,
    parameter int ActiveHeight = 720,
    parameter int IslandOffset = 4,
    parameter int NumSources   = 3,
    parameter int FifoDepth    = 4,
    parameter int MaxIsland    = 2
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic [BitWidth-1:0]  x,
    input  wire logic [BitHeight-1:0] y,
    h14tx_island_scheduler_if.slave   bus
);
    localparam int XS      = ActiveWidth + IslandOffset;
    localparam int MaxFit  = (FrameWidth - MinControlLen - VideoLeadLen - XS - MinControlLen) / PacketCycles;
    localparam int CAP     = (MaxIsland < MaxFit) ? MaxIsland : MaxFit;
    localparam int PtrW    = (NumSources > 1) ? $clog2(NumSources) : 1;
    localparam int LevelW  = $clog2(FifoDepth) + 1;

    localparam logic [BitWidth-1:0]  X_START  = BitWidth'(XS);
    localparam logic [BitWidth-1:0]  X_ACT    = BitWidth'(ActiveWidth);
    localparam logic [BitWidth-1:0]  X_VPRE   = BitWidth'(FrameWidth - VideoLeadLen);
    localparam logic [BitWidth-1:0]  X_VGUARD = BitWidth'(FrameWidth - GuardLen);
    localparam logic [BitWidth-1:0]  X_END    = BitWidth'(FrameWidth);
    localparam logic [BitHeight-1:0] Y_ACT    = BitHeight'(ActiveHeight);
    localparam logic [BitHeight-1:0] Y_PRELST = BitHeight'(ActiveHeight - 1);
    localparam logic [BitHeight-1:0] Y_LAST   = BitHeight'(FrameHeight - 1);

    if (MaxFit < 1) begin : g_fit_check
        $error("island window cannot hold a single packet");
    end
    if (MaxIsland < 1 || MaxIsland > MaxPacketsPerIsland || NumSources < 1 || NumSources > 8) begin : g_param_check
        $error("MaxIsland or NumSources out of range");
    end

    island_state_t          r_state;
    period_t                r_period;
    packet_t                r_packet;
    logic                   r_pkt_start;
    logic [2:0]             r_pre;
    logic [4:0]             r_chunk;
    logic [4:0]             r_pcnt;
    logic [4:0]             r_n;
    logic [NumSources-1:0]  r_ready;
    logic [PtrW-1:0]        r_ptr;
    logic [PtrW-1:0]        r_gnt;

    period_t                w_video;
    logic                   w_next_active;
    logic [4:0]             w_n;
    logic                   w_start;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_will_full;
    logic [LevelW-1:0]      w_level;
    packet_t                w_head;
    logic [PtrW-1:0]        w_base;
    logic [PtrW-1:0]        w_after_gnt;
    logic [NumSources-1:0]  w_rot;
    logic [PtrW:0]          w_k;
    logic [PtrW:0]          w_sum;
    logic [PtrW-1:0]        w_gnt;
    logic                   w_found;

    h14tx_packet_fifo #(.Depth(FifoDepth)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (bus.src_packet[r_gnt]),
        .pop       (w_pop),
        .head      (w_head),
        .level     (w_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign w_next_active = (y < Y_PRELST) || (y == Y_LAST);
    assign w_push        = |(bus.src_valid & r_ready) && !w_full;
    assign w_pop         = (r_state == S_ACTIVE) && (r_chunk == 5'(PacketCycles - 1)) && !w_empty;
    assign w_will_full   = (int'(w_level) + int'(w_push) - int'(w_pop)) >= FifoDepth;
    assign w_after_gnt   = (r_gnt == PtrW'(NumSources - 1)) ? '0 : r_gnt + 1'b1;
    assign w_start       = (r_state == S_IDLE) && (x == X_START) && (w_n != 5'd0);

    always_comb begin
        w_video = Control;
        if (x < X_ACT && y < Y_ACT)
            w_video = VideoActive;
        else if (w_next_active && x >= X_VPRE && x < X_VGUARD)
            w_video = VideoPreamble;
        else if (w_next_active && x >= X_VGUARD && x < X_END)
            w_video = VideoGuard;
    end

    always_comb begin
        w_n = 5'(CAP);
        if (int'(w_level) < CAP) w_n = 5'(w_level);
    end

    // Search starts just past the source accepted this cycle, else at the pointer.
    always_comb begin
        w_base  = w_push ? w_after_gnt : r_ptr;
        w_rot   = NumSources'({bus.src_valid, bus.src_valid} >> w_base);
        w_k     = '0;
        w_found = 1'b0;
        for (int i = NumSources - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_k     = (PtrW+1)'(i);
            end
        end
        w_sum = {1'b0, w_base} + w_k;
        if (w_sum >= (PtrW+1)'(NumSources)) w_sum = w_sum - (PtrW+1)'(NumSources);
        w_gnt = w_sum[PtrW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= '0;
            r_ptr   <= '0;
            r_gnt   <= '0;
        end else begin
            r_ready <= (w_found && !w_will_full) ? (NumSources'(1) << w_gnt) : '0;
            r_gnt   <= w_gnt;
            if (w_push) r_ptr <= w_after_gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_period    <= Control;
            r_packet    <= '0;
            r_pkt_start <= 1'b0;
            r_pre       <= '0;
            r_chunk     <= '0;
            r_pcnt      <= '0;
            r_n         <= '0;
        end else begin
            r_packet    <= '0;
            r_pkt_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_period <= DataIslandPreamble;
                        r_pre    <= 3'd1;
                        r_n      <= w_n;
                        r_state  <= S_PRE;
                    end else begin
                        r_period <= w_video;
                    end
                end
                S_PRE: begin
                    r_period <= DataIslandPreamble;
                    r_pre    <= r_pre + 1'b1;
                    if (r_pre == 3'(IslandPreambleLen - 1)) begin
                        r_pre   <= '0;
                        r_state <= S_LGUARD;
                    end
                end
                S_LGUARD: begin
                    r_period <= DataIslandGuard;
                    r_pre    <= r_pre + 1'b1;
                    if (r_pre == 3'(GuardLen - 1)) begin
                        r_pre   <= '0;
                        r_chunk <= '0;
                        r_pcnt  <= '0;
                        r_state <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    r_period    <= DataIslandActive;
                    r_packet    <= w_head;
                    r_pkt_start <= (r_chunk == 5'd0);
                    r_chunk     <= r_chunk + 1'b1;
                    if (r_chunk == 5'(PacketCycles - 1)) begin
                        r_pcnt <= r_pcnt + 1'b1;
                        if (r_pcnt == r_n - 1'b1) r_state <= S_TGUARD;
                    end
                end
                S_TGUARD: begin
                    r_period <= DataIslandGuard;
                    r_pre    <= r_pre + 1'b1;
                    if (r_pre == 3'(GuardLen - 1)) begin
                        r_pre   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.src_ready  = r_ready;
    assign bus.period     = r_period;
    assign bus.packet     = r_packet;
    assign bus.pkt_start  = r_pkt_start;
    assign bus.fifo_level = w_level;
endmodule
`default_nettype wire
